// File: rtl/id_ex_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the 5-stage core. Captures the operands,
// immediate, PC+4, source fields and control bundle of the ID instruction on
// each rising edge. It also detects load-use hazards, stalls the front end
// and inserts a bubble into EX. A branch/jump flush kills the ID instruction.
// A saturating counter records the number of stall cycles.
//
// Ports
//   i_clk, i_reset        rising-edge clock, synchronous active-high reset
//   i_valid, i_flush      ID holds a valid instruction / kill it
//   i_rs, i_rt, i_rd      register fields of the ID instruction
//   i_read_data_1/2       register-file operands
//   i_imm, i_pc_plus4     sign-extended immediate, PC+4
//   i_ctrl                {reg_write, mem_to_reg, mem_read, mem_write,
//                          reg_dst, alu_src, alu_op[1:0]}
//   o_stall               hold PC and IF/ID this cycle (combinational)
//   o_valid, o_ctrl       EX instruction valid, registered control bundle
//   o_read_data_1/2, o_imm, o_pc_plus4, o_rs, o_rt, o_write_reg
//                         registered EX fields
//   o_stall_count         saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    input  logic         i_flush,
    input  logic [W-1:0] i_rs,
    input  logic [W-1:0] i_rt,
    input  logic [W-1:0] i_rd,
    input  logic [B-1:0] i_read_data_1,
    input  logic [B-1:0] i_read_data_2,
    input  logic [B-1:0] i_imm,
    input  logic [B-1:0] i_pc_plus4,
    input  logic [7:0]   i_ctrl,
    output logic         o_stall,
    output logic         o_valid,
    output logic [7:0]   o_ctrl,
    output logic [B-1:0] o_read_data_1,
    output logic [B-1:0] o_read_data_2,
    output logic [B-1:0] o_imm,
    output logic [B-1:0] o_pc_plus4,
    output logic [W-1:0] o_rs,
    output logic [W-1:0] o_rt,
    output logic [W-1:0] o_write_reg,
    output logic [15:0]  o_stall_count
);

    // Bit positions inside the control bundle.
    localparam int CTRL_MEM_READ = 5;
    localparam int CTRL_REG_DST  = 3;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic         hazard;
    logic         bubble;
    logic [W-1:0] write_reg_next;

    // A load in EX whose destination (non-zero) is read by the valid ID
    // instruction. This depends only on EX state and the ID register fields,
    // never on the read data, so it stays off the register-file timing path.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hazard = 1'b0;
        if (o_valid && o_ctrl[CTRL_MEM_READ] && (o_rt != '0) && i_valid &&
            ((o_rt == i_rs) || (o_rt == i_rt))) begin
            hazard = 1'b1;
        end
    end

    // A flush kills the ID instruction, so no stall is needed.
    assign o_stall = hazard && !i_flush;

    // A flush or a hazard loads a bubble.
    assign bubble = i_flush || hazard;

    // The destination register is resolved before the pipeline register.
    assign write_reg_next = i_ctrl[CTRL_REG_DST] ? i_rd : i_rt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid       <= 1'b0;
            o_ctrl        <= '0;
            o_read_data_1 <= '0;
            o_read_data_2 <= '0;
            o_imm         <= '0;
            o_pc_plus4    <= '0;
            o_rs          <= '0;
            o_rt          <= '0;
            o_write_reg   <= '0;
            o_stall_count <= '0;
        end else begin
            if (bubble) begin
                o_valid <= 1'b0;
                o_ctrl  <= '0;
            end else begin
                o_valid <= i_valid;
                o_ctrl  <= i_valid ? i_ctrl : '0;
            end

            // Data fields are captured even for bubbles. Only valid and
            // control are cleared, so a bubble has no side effects.
            o_read_data_1 <= i_read_data_1;
            o_read_data_2 <= i_read_data_2;
            o_imm         <= i_imm;
            o_pc_plus4    <= i_pc_plus4;
            o_rs          <= i_rs;
            o_rt          <= i_rt;
            o_write_reg   <= write_reg_next;

            if (o_stall && (o_stall_count != COUNT_MAX)) begin
                o_stall_count <= o_stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. A behavioural model predicts the EX
// fields, the stall output and the stall count from the pipeline rules. A
// compare process checks the DUT against the model on every falling edge.
// Directed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int B = 32;
    localparam int W = 5;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_valid;
    logic         i_flush;
    logic [W-1:0] i_rs, i_rt, i_rd;
    logic [B-1:0] i_read_data_1, i_read_data_2, i_imm, i_pc_plus4;
    logic [7:0]   i_ctrl;
    logic         o_stall, o_valid;
    logic [7:0]   o_ctrl;
    logic [B-1:0] o_read_data_1, o_read_data_2, o_imm, o_pc_plus4;
    logic [W-1:0] o_rs, o_rt, o_write_reg;
    logic [15:0]  o_stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.B(B), .W(W)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_flush       (i_flush),
        .i_rs          (i_rs),
        .i_rt          (i_rt),
        .i_rd          (i_rd),
        .i_read_data_1 (i_read_data_1),
        .i_read_data_2 (i_read_data_2),
        .i_imm         (i_imm),
        .i_pc_plus4    (i_pc_plus4),
        .i_ctrl        (i_ctrl),
        .o_stall       (o_stall),
        .o_valid       (o_valid),
        .o_ctrl        (o_ctrl),
        .o_read_data_1 (o_read_data_1),
        .o_read_data_2 (o_read_data_2),
        .o_imm         (o_imm),
        .o_pc_plus4    (o_pc_plus4),
        .o_rs          (o_rs),
        .o_rt          (o_rt),
        .o_write_reg   (o_write_reg),
        .o_stall_count (o_stall_count)
    );

    always #5 i_clk = ~i_clk;

    // Control bundles used by the stimulus.
    localparam logic [7:0] CTRL_LW     = 8'hE4; // reg_write, mem_to_reg, mem_read, alu_src
    localparam logic [7:0] CTRL_R_DST  = 8'h8E; // reg_write, reg_dst, alu_src, alu_op=2
    localparam logic [7:0] CTRL_R_NDST = 8'h86; // same bundle with reg_dst = 0

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           model_on  = 1'b0;
    bit           m_force_hz = 1'b0; // EX held as a matching load by force
    bit           m_valid   = 1'b0;
    logic [7:0]   m_ctrl    = '0;
    logic [B-1:0] m_rd1 = '0, m_rd2 = '0, m_imm = '0, m_pc = '0;
    logic [W-1:0] m_rs = '0, m_rt = '0, m_wr = '0;
    int           m_cnt = 0;

    function automatic bit model_hazard();
        if (m_force_hz)
            return 1'b1;
        return m_valid && m_ctrl[5] && (m_rt != 0) && i_valid &&
               ((m_rt == i_rs) || (m_rt == i_rt));
    endfunction

    always @(posedge i_clk) begin
        bit hz;
        hz = model_hazard();
        if (i_reset) begin
            m_valid = 1'b0; m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
            m_pc = '0; m_rs = '0; m_rt = '0; m_wr = '0; m_cnt = 0;
        end else begin
            if (hz && !i_flush && m_cnt < 65535)
                m_cnt = m_cnt + 1;
            if (i_flush || hz) begin
                m_valid = 1'b0;
                m_ctrl  = '0;
            end else begin
                m_valid = i_valid;
                m_ctrl  = i_valid ? i_ctrl : 8'h00;
            end
            m_rd1 = i_read_data_1; m_rd2 = i_read_data_2; m_imm = i_imm;
            m_pc  = i_pc_plus4;    m_rs  = i_rs;          m_rt  = i_rt;
            m_wr  = i_ctrl[3] ? i_rd : i_rt;
        end
    end

    always @(negedge i_clk) begin
        if (model_on) begin
            check("stall",       32'(o_stall),       32'(model_hazard() && !i_flush));
            check("valid",       32'(o_valid),       32'(m_valid));
            check("ctrl",        32'(o_ctrl),        32'(m_ctrl));
            check("read_data_1", o_read_data_1,      m_rd1);
            check("read_data_2", o_read_data_2,      m_rd2);
            check("imm",         o_imm,              m_imm);
            check("pc_plus4",    o_pc_plus4,         m_pc);
            check("rs",          32'(o_rs),          32'(m_rs));
            check("rt",          32'(o_rt),          32'(m_rt));
            check("write_reg",   32'(o_write_reg),   32'(m_wr));
            check("stall_count", 32'(o_stall_count), 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    logic [B-1:0] pc = 32'h0000_1000;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input bit valid, input bit flush, input int rs, input int rt,
                         input int rd, input logic [7:0] ctrl, input logic [B-1:0] rd1);
        i_valid       = valid;
        i_flush       = flush;
        i_rs          = W'(rs);
        i_rt          = W'(rt);
        i_rd          = W'(rd);
        i_ctrl        = ctrl;
        i_read_data_1 = rd1;
        i_read_data_2 = ~rd1;
        i_imm         = rd1 ^ 32'h0000_5A5A;
        pc            = pc + 32'd4;
        i_pc_plus4    = pc;
    endtask

    initial begin
        // Reset with every input non-zero.
        i_reset = 1'b1;
        drive(1, 1, 8, 8, 12, 8'hFF, 32'hDEAD_BEEF);
        tick();
        model_on = 1'b1;
        tick();
        check("reset valid",       32'(o_valid),       32'd0);
        check("reset ctrl",        32'(o_ctrl),        32'd0);
        check("reset read_data_1", o_read_data_1,      32'd0);
        check("reset write_reg",   32'(o_write_reg),   32'd0);
        check("reset stall",       32'(o_stall),       32'd0);
        check("reset stall_count", 32'(o_stall_count), 32'd0);
        i_reset = 1'b0;

        // Pass-through. 8'h8E has reg_dst set, so rd is selected. 8'h86
        // clears reg_dst, so rt is selected.
        drive(1, 0, 1, 9, 12, CTRL_R_DST, 32'h1234);
        tick();
        check("pass ctrl",        32'(o_ctrl),      32'h8E);
        check("pass read_data_1", o_read_data_1,    32'h1234);
        check("pass write_reg rd", 32'(o_write_reg), 32'd12);
        drive(1, 0, 1, 9, 12, CTRL_R_NDST, 32'h5678);
        tick();
        check("pass write_reg rt", 32'(o_write_reg), 32'd9);

        // Load-use: lw to $8, followed by an instruction reading $8 as rs.
        drive(1, 0, 2, 8, 0, CTRL_LW, 32'h100);
        tick();
        drive(1, 0, 8, 5, 6, CTRL_R_DST, 32'h200);
        #1;
        check("loaduse stall", 32'(o_stall), 32'd1);
        tick();
        check("loaduse bubble valid", 32'(o_valid),       32'd0);
        check("loaduse bubble ctrl",  32'(o_ctrl),        32'd0);
        check("loaduse stall off",    32'(o_stall),       32'd0);
        check("loaduse count",        32'(o_stall_count), 32'd1);
        tick();
        check("loaduse enters valid", 32'(o_valid), 32'd1);
        check("loaduse enters ctrl",  32'(o_ctrl),  32'h8E);

        // No false hazard: lw to $0, then lw to $8 with an unrelated reader.
        drive(1, 0, 3, 0, 0, CTRL_LW, 32'h300);
        tick();
        drive(1, 0, 0, 1, 2, CTRL_R_DST, 32'h301);
        #1;
        check("lw $0 no stall", 32'(o_stall), 32'd0);
        drive(1, 0, 2, 8, 0, CTRL_LW, 32'h302);
        tick();
        drive(1, 0, 3, 4, 2, CTRL_R_DST, 32'h303);
        #1;
        check("unrelated no stall", 32'(o_stall), 32'd0);
        tick();
        check("no false count", 32'(o_stall_count), 32'd1);

        // Flush and hazard together: the flush wins.
        drive(1, 0, 2, 8, 0, CTRL_LW, 32'h400);
        tick();
        drive(1, 1, 8, 8, 2, CTRL_R_DST, 32'h401);
        #1;
        check("flush stall", 32'(o_stall), 32'd0);
        tick();
        check("flush bubble", 32'(o_valid),       32'd0);
        check("flush count",  32'(o_stall_count), 32'd1);

        // An invalid ID instruction never stalls. The bubble propagates.
        drive(1, 0, 2, 8, 0, CTRL_LW, 32'h500);
        tick();
        drive(0, 0, 8, 8, 2, CTRL_R_DST, 32'h501);
        #1;
        check("invalid no stall", 32'(o_stall), 32'd0);
        tick();
        check("invalid bubble ctrl", 32'(o_ctrl), 32'd0);

        // Reset during a stall cycle.
        drive(1, 0, 2, 8, 0, CTRL_LW, 32'h600);
        tick();
        drive(1, 0, 8, 1, 2, CTRL_R_DST, 32'h601);
        #1;
        check("midreset stall", 32'(o_stall), 32'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("midreset count", 32'(o_stall_count), 32'd0);
        check("midreset stall off", 32'(o_stall), 32'd0);

        // Saturation: hold a matching load in EX so every edge stalls.
        drive(1, 0, 8, 8, 2, CTRL_R_DST, 32'h700);
        force dut.o_valid = 1'b1;
        force dut.o_ctrl  = CTRL_LW;
        force dut.o_rt    = 5'd8;
        model_on   = 1'b0;
        m_force_hz = 1'b1;
        repeat (65540) @(posedge i_clk);
        #1;
        check("saturate count", 32'(o_stall_count), 32'hFFFF);
        check("saturate stall", 32'(o_stall),       32'd1);
        // Release behind a flush edge so EX reloads cleanly.
        i_flush = 1'b1;
        release dut.o_valid;
        release dut.o_ctrl;
        release dut.o_rt;
        m_force_hz = 1'b0;
        tick();
        model_on = 1'b1;
        // One more real stall must not wrap the counter.
        drive(1, 0, 2, 8, 0, CTRL_LW, 32'h800);
        tick();
        drive(1, 0, 8, 5, 6, CTRL_R_DST, 32'h801);
        tick();
        check("saturate hold", 32'(o_stall_count), 32'hFFFF);
        tick();
        tick();

        model_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
